// File: rtl/alu_exec_stage_pkg.sv
// Shared definitions for the LEGv8 execute stage: word size, opcodes,
// ALUOp encodings and the 4-bit ALU operation codes.
package alu_exec_stage_pkg;

    localparam int WORD  = 64;
    localparam int CYCLE = 10;

    // 11-bit instruction opcodes, bits [31:21]; CBZ and B are padded with zeros
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_B    = 11'b00010100000;

    localparam logic [1:0] ALUOP_DTYPE  = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_ORR   = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111,
        ALU_NOR   = 4'b1100,
        ALU_BAD   = 4'b1111
    } alu_ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control: maps main-control ALUOp and the instruction
// opcode to a 4-bit ALU operation plus an illegal-encoding flag.
module alu_ctrl_decode
    import alu_exec_stage_pkg::*;
(
    input  logic [1:0]  alu_op,
    input  logic [10:0] opcode,
    output logic [3:0]  control,
    output logic        illegal
);

    always_comb begin
        control = ALU_BAD;
        illegal = 1'b0;
        unique case (alu_op)
            ALUOP_DTYPE:  control = ALU_ADD;
            ALUOP_BRANCH: control = ALU_PASSB;
            ALUOP_RTYPE: begin
                // only the full opcode selects an R-type op; anything else is flagged
                case (opcode)
                    OP_ADD:  control = ALU_ADD;
                    OP_SUB:  control = ALU_SUB;
                    OP_AND:  control = ALU_AND;
                    OP_ORR:  control = ALU_ORR;
                    default: begin
                        control = ALU_BAD;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                control = ALU_BAD;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// LEGv8 execute stage: decodes the ALU operation, computes it and registers
// result, zero, illegal and valid for the next pipeline stage.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int WIDTH = WORD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [1:0]       alu_op,
    input  logic [10:0]      opcode,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    output logic [3:0]       control,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             valid_out
);

    // valid_in only qualifies the data; there is no ready and no stall, so
    // every cycle is accepted and valid_out is valid_in delayed by one clock.
    logic             dec_illegal;
    logic [WIDTH-1:0] alu_out;

    alu_ctrl_decode u_decode (
        .alu_op  (alu_op),
        .opcode  (opcode),
        .control (control),
        .illegal (dec_illegal)
    );

    always_comb begin
        alu_out = '0;
        case (control)
            ALU_AND:   alu_out = data_1 & data_2;
            ALU_ORR:   alu_out = data_1 | data_2;
            ALU_ADD:   alu_out = data_1 + data_2;
            ALU_SUB:   alu_out = data_1 - data_2;
            ALU_PASSB: alu_out = data_2;
            ALU_NOR:   alu_out = ~(data_1 | data_2);
            default:   alu_out = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            result    <= alu_out;
            zero      <= (alu_out == '0);
            illegal   <= dec_illegal;
            valid_out <= valid_in;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: hand-computed vectors applied one per
// cycle, control checked combinationally and outputs one cycle later.
module tb_alu_exec_stage;
    import alu_exec_stage_pkg::*;

    localparam int W = WORD;

    logic          clk;
    logic          reset;
    logic          valid_in;
    logic [1:0]    alu_op;
    logic [10:0]   opcode;
    logic [W-1:0]  data_1;
    logic [W-1:0]  data_2;
    logic [3:0]    control;
    logic [W-1:0]  result;
    logic          zero;
    logic          illegal;
    logic          valid_out;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    alu_exec_stage #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .alu_op    (alu_op),
        .opcode    (opcode),
        .data_1    (data_1),
        .data_2    (data_2),
        .control   (control),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .valid_out (valid_out)
    );

    // clock and reset
    initial clk = 1'b0;
    always #(CYCLE / 2) clk = ~clk;

    initial begin
        #(CYCLE * 2000);
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // drive one vector at the falling edge, check decode, then registered outputs
    task automatic apply(input string tag, input logic [1:0] op, input logic [10:0] opc,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic vin,
                         input logic [3:0] exp_ctrl, input logic [W-1:0] exp_res,
                         input logic exp_zero, input logic exp_ill);
        logic [W-1:0] exp_r;
        @(negedge clk);
        alu_op   = op;
        opcode   = opc;
        data_1   = a;
        data_2   = b;
        valid_in = vin;
        exp_q.push_back(exp_res);
        #1;
        check({tag, "_control"}, W'(control), W'(exp_ctrl));
        @(posedge clk);
        #1;
        exp_r = exp_q.pop_front();
        check({tag, "_result"}, result, exp_r);
        check({tag, "_zero"}, W'(zero), W'(exp_zero));
        check({tag, "_illegal"}, W'(illegal), W'(exp_ill));
        check({tag, "_valid"}, W'(valid_out), W'(vin));
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        alu_op   = 2'b00;
        opcode   = '0;
        data_1   = '0;
        data_2   = '0;
        #3;
        check("rst_result", result, '0);
        check("rst_zero", W'(zero), '0);
        check("rst_illegal", W'(illegal), '0);
        check("rst_valid", W'(valid_out), '0);
        @(negedge clk);
        reset = 1'b0;

        apply("add",  ALUOP_RTYPE,  OP_ADD,  64'd15, 64'd10, 1'b1, 4'b0010, 64'd25, 1'b0, 1'b0);
        apply("sub",  ALUOP_RTYPE,  OP_SUB,  64'd15, 64'd10, 1'b1, 4'b0110, 64'd5,  1'b0, 1'b0);
        apply("and",  ALUOP_RTYPE,  OP_AND,  64'd15, 64'd10, 1'b1, 4'b0000, 64'd10, 1'b0, 1'b0);
        apply("orr",  ALUOP_RTYPE,  OP_ORR,  64'd15, 64'd10, 1'b1, 4'b0001, 64'd15, 1'b0, 1'b0);
        apply("ldur", ALUOP_DTYPE,  OP_LDUR, 64'd15, 64'd10, 1'b1, 4'b0010, 64'd25, 1'b0, 1'b0);
        apply("stur", ALUOP_DTYPE,  OP_STUR, 64'd15, 64'd10, 1'b0, 4'b0010, 64'd25, 1'b0, 1'b0);
        apply("cbz",  ALUOP_BRANCH, OP_CBZ,  64'd15, 64'd10, 1'b1, 4'b0111, 64'd10, 1'b0, 1'b0);
        apply("b",    ALUOP_BRANCH, OP_B,    64'd15, 64'd10, 1'b1, 4'b0111, 64'd10, 1'b0, 1'b0);
        apply("cbz_z", ALUOP_BRANCH, OP_CBZ, 64'd15, 64'd0,  1'b1, 4'b0111, 64'd0,  1'b1, 1'b0);
        apply("cbz_a0", ALUOP_BRANCH, OP_CBZ, 64'd0, 64'd5,  1'b1, 4'b0111, 64'd5,  1'b0, 1'b0);
        apply("sub_z", ALUOP_RTYPE, OP_SUB,  64'd15, 64'd15, 1'b1, 4'b0110, 64'd0,  1'b1, 1'b0);
        apply("add_wrap", ALUOP_RTYPE, OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1,
              4'b0010, 64'd0, 1'b1, 1'b0);
        apply("sub_wrap", ALUOP_RTYPE, OP_SUB, 64'd0, 64'd1, 1'b1,
              4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        apply("and_mix", ALUOP_RTYPE, OP_AND, 64'hF0F0_1234_0000_FFFF, 64'h0FF0_FF00_1111_00F0,
              1'b1, 4'b0000, 64'h00F0_1200_0000_00F0, 1'b0, 1'b0);
        apply("rt_bad", ALUOP_RTYPE, 11'b00000000000, 64'd15, 64'd10, 1'b1, 4'b1111, 64'd0, 1'b1, 1'b1);
        apply("op11",  2'b11, OP_ADD, 64'd15, 64'd10, 1'b1, 4'b1111, 64'd0, 1'b1, 1'b1);
        apply("orr_after_bad", ALUOP_RTYPE, OP_ORR, 64'h8000_0000_0000_0000, 64'd1, 1'b1,
              4'b0001, 64'h8000_0000_0000_0001, 1'b0, 1'b0);

        // asynchronous reset between edges clears outputs without a clock
        #2;
        reset = 1'b1;
        #1;
        check("arst_result", result, '0);
        check("arst_zero", W'(zero), '0);
        check("arst_valid", W'(valid_out), '0);
        @(negedge clk);
        reset = 1'b0;
        apply("post_rst", ALUOP_RTYPE, OP_ADD, 64'd1, 64'd2, 1'b1, 4'b0010, 64'd3, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
